// File: rtl/spiral_pkg.sv
// Shared types, size codes, golden coefficient table and per-lane
// shift/add recipes for the HEVC odd-part multiple-constant multiplier.
package spiral_pkg;

  localparam int NUM_LANES = 16;
  localparam int COEF_W    = 7;
  localparam int NUM_PART  = 7;

  typedef enum logic [1:0] {
    SZ_4  = 2'd0,
    SZ_8  = 2'd1,
    SZ_16 = 2'd2,
    SZ_32 = 2'd3
  } size_e;

  // Golden odd-row coefficients, indexed [size][lane]; unused lanes are 0.
  localparam int COEF_TAB [4][NUM_LANES] = '{
    '{83, 36,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0, 0},
    '{89, 75, 50, 18,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0, 0},
    '{90, 87, 80, 70, 57, 43, 25,  9,  0,  0,  0,  0,  0,  0,  0, 0},
    '{90, 90, 88, 85, 82, 78, 73, 67, 61, 54, 46, 38, 31, 22, 13, 4}
  };

  // Index of each shared partial term on the S1 partial bus.
  localparam logic [2:0] P1  = 3'd0;
  localparam logic [2:0] P3  = 3'd1;
  localparam logic [2:0] P5  = 3'd2;
  localparam logic [2:0] P9  = 3'd3;
  localparam logic [2:0] P17 = 3'd4;
  localparam logic [2:0] P33 = 3'd5;
  localparam logic [2:0] P65 = 3'd6;

  // coef = (part[a_sel] << a_sh) +/- (part[b_sel] << b_sh), or 0 if inactive.
  typedef struct packed {
    logic       active;
    logic [2:0] a_sel;
    logic [2:0] a_sh;
    logic       use_b;
    logic [2:0] b_sel;
    logic [2:0] b_sh;
    logic       b_sub;
  } recipe_t;

  function automatic recipe_t rc(input logic [2:0] a_sel, input logic [2:0] a_sh,
                                 input logic [2:0] b_sel, input logic [2:0] b_sh,
                                 input logic use_b, input logic b_sub);
    recipe_t r;
    r.active = 1'b1;
    r.a_sel  = a_sel;
    r.a_sh   = a_sh;
    r.use_b  = use_b;
    r.b_sel  = b_sel;
    r.b_sh   = b_sh;
    r.b_sub  = b_sub;
    return r;
  endfunction

  // Single-term recipe: part[a_sel] << a_sh.
  function automatic recipe_t rc1(input logic [2:0] a_sel, input logic [2:0] a_sh);
    return rc(a_sel, a_sh, P1, 3'd0, 1'b0, 1'b0);
  endfunction

  // Shift/add decomposition of every coefficient, per lane and size.
  function automatic recipe_t recipe_f(input int lane, input logic [1:0] size);
    recipe_t r;
    r = '0;
    case (size)
      2'd0: begin
        case (lane)
          0: r = rc(P65, 3'd0, P9, 3'd1, 1'b1, 1'b0);   // 83
          1: r = rc1(P9, 3'd2);                         // 36
          default: r = '0;
        endcase
      end
      2'd1: begin
        case (lane)
          0: r = rc(P65, 3'd0, P3, 3'd3, 1'b1, 1'b0);   // 89
          1: r = rc(P65, 3'd0, P5, 3'd1, 1'b1, 1'b0);   // 75
          2: r = rc(P17, 3'd1, P1, 3'd4, 1'b1, 1'b0);   // 50
          3: r = rc1(P9, 3'd1);                         // 18
          default: r = '0;
        endcase
      end
      2'd2: begin
        case (lane)
          0: r = rc(P33, 3'd1, P3, 3'd3, 1'b1, 1'b0);   // 90
          1: r = rc(P3, 3'd5, P9, 3'd0, 1'b1, 1'b1);    // 87
          2: r = rc1(P5, 3'd4);                         // 80
          3: r = rc(P65, 3'd0, P5, 3'd0, 1'b1, 1'b0);   // 70
          4: r = rc(P65, 3'd0, P1, 3'd3, 1'b1, 1'b1);   // 57
          5: r = rc(P33, 3'd0, P5, 3'd1, 1'b1, 1'b0);   // 43
          6: r = rc(P17, 3'd0, P1, 3'd3, 1'b1, 1'b0);   // 25
          7: r = rc1(P9, 3'd0);                         // 9
          default: r = '0;
        endcase
      end
      2'd3: begin
        case (lane)
          0:  r = rc(P33, 3'd1, P3, 3'd3, 1'b1, 1'b0);  // 90
          1:  r = rc(P33, 3'd1, P3, 3'd3, 1'b1, 1'b0);  // 90
          2:  r = rc(P3, 3'd5, P1, 3'd3, 1'b1, 1'b1);   // 88
          3:  r = rc(P65, 3'd0, P5, 3'd2, 1'b1, 1'b0);  // 85
          4:  r = rc(P65, 3'd0, P17, 3'd0, 1'b1, 1'b0); // 82
          5:  r = rc(P33, 3'd1, P3, 3'd2, 1'b1, 1'b0);  // 78
          6:  r = rc(P65, 3'd0, P1, 3'd3, 1'b1, 1'b0);  // 73
          7:  r = rc(P65, 3'd0, P1, 3'd1, 1'b1, 1'b0);  // 67
          8:  r = rc(P65, 3'd0, P1, 3'd2, 1'b1, 1'b1);  // 61
          9:  r = rc(P9, 3'd2, P9, 3'd1, 1'b1, 1'b0);   // 54
          10: r = rc(P3, 3'd4, P1, 3'd1, 1'b1, 1'b1);   // 46
          11: r = rc(P33, 3'd0, P5, 3'd0, 1'b1, 1'b0);  // 38
          12: r = rc(P33, 3'd0, P1, 3'd1, 1'b1, 1'b1);  // 31
          13: r = rc(P17, 3'd0, P5, 3'd0, 1'b1, 1'b0);  // 22
          14: r = rc(P9, 3'd0, P1, 3'd2, 1'b1, 1'b0);   // 13
          15: r = rc1(P1, 3'd2);                        // 4
          default: r = '0;
        endcase
      end
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/spiral_odd_lane.sv
// One output lane: builds its product for each transform size from the shared
// S1 partials with constant shifts and one add/sub, selects by size, registers.
module spiral_odd_lane
  import spiral_pkg::*;
#(
  parameter int LANE  = 0,
  parameter int OUT_W = 25
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_en,
  input  logic signed [OUT_W-1:0] i_part [0:NUM_PART-1],
  input  logic [1:0]              i_size,
  output logic signed [OUT_W-1:0] o_data
);

  logic signed [OUT_W-1:0] prod_s [0:3];
  logic signed [OUT_W-1:0] data_d;
  logic signed [OUT_W-1:0] data_q;

  for (genvar s = 0; s < 4; s++) begin : g_size
    localparam recipe_t R = recipe_f(LANE, 2'(s));
    if (!R.active) begin : g_off
      assign prod_s[s] = '0;
    end else begin : g_on
      logic signed [OUT_W-1:0] term_a;
      logic signed [OUT_W-1:0] term_b;
      assign term_a = i_part[R.a_sel] <<< R.a_sh;
      if (R.use_b) begin : g_b
        assign term_b = i_part[R.b_sel] <<< R.b_sh;
      end else begin : g_nb
        assign term_b = '0;
      end
      assign prod_s[s] = R.b_sub ? (term_a - term_b) : (term_a + term_b);
    end
  end

  // Next output: the product for the registered size, or hold while stalled.
  always_comb begin
    data_d = data_q;
    if (i_en) begin
      data_d = prod_s[i_size];
    end else begin
      data_d = data_q;
    end
  end

  // S2 output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign o_data = data_q;

endmodule

// File: rtl/spiral_mcm_pipe.sv
// Two-stage size-switchable multiple-constant multiplier for the HEVC DCT
// odd-part butterflies. S1 registers the sample's shared partial products,
// S2 (inside each lane) forms and registers the per-lane products.
module spiral_mcm_pipe
  import spiral_pkg::*;
#(
  parameter int IN_W  = 18,
  parameter int OUT_W = IN_W + 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_en,
  input  logic                    i_valid,
  input  logic [1:0]              i_size,
  input  logic signed [IN_W-1:0]  i_data,
  output logic                    o_valid,
  output logic [1:0]              o_size,
  output logic signed [OUT_W-1:0] o_data_0,
  output logic signed [OUT_W-1:0] o_data_1,
  output logic signed [OUT_W-1:0] o_data_2,
  output logic signed [OUT_W-1:0] o_data_3,
  output logic signed [OUT_W-1:0] o_data_4,
  output logic signed [OUT_W-1:0] o_data_5,
  output logic signed [OUT_W-1:0] o_data_6,
  output logic signed [OUT_W-1:0] o_data_7,
  output logic signed [OUT_W-1:0] o_data_8,
  output logic signed [OUT_W-1:0] o_data_9,
  output logic signed [OUT_W-1:0] o_data_10,
  output logic signed [OUT_W-1:0] o_data_11,
  output logic signed [OUT_W-1:0] o_data_12,
  output logic signed [OUT_W-1:0] o_data_13,
  output logic signed [OUT_W-1:0] o_data_14,
  output logic signed [OUT_W-1:0] o_data_15
);

  logic signed [OUT_W-1:0] x_s;
  logic signed [OUT_W-1:0] part_d [0:NUM_PART-1];
  logic signed [OUT_W-1:0] part_q [0:NUM_PART-1];
  logic [1:0]              size1_d, size1_q, size2_d, size2_q;
  logic                    vld1_d, vld1_q, vld2_d, vld2_q;
  logic signed [OUT_W-1:0] lane_s [0:NUM_LANES-1];

  assign x_s = {{(OUT_W-IN_W){i_data[IN_W-1]}}, i_data};

  // S1 next state: shared partials x1..x65 plus the size/valid tags.
  always_comb begin
    part_d  = part_q;
    size1_d = size1_q;
    vld1_d  = vld1_q;
    size2_d = size2_q;
    vld2_d  = vld2_q;
    if (i_en) begin
      part_d[P1]  = x_s;
      part_d[P3]  = (x_s <<< 1) + x_s;
      part_d[P5]  = (x_s <<< 2) + x_s;
      part_d[P9]  = (x_s <<< 3) + x_s;
      part_d[P17] = (x_s <<< 4) + x_s;
      part_d[P33] = (x_s <<< 5) + x_s;
      part_d[P65] = (x_s <<< 6) + x_s;
      size1_d     = i_size;
      vld1_d      = i_valid;
      size2_d     = size1_q;
      vld2_d      = vld1_q;
    end else begin
      part_d  = part_q;
      size1_d = size1_q;
      vld1_d  = vld1_q;
      size2_d = size2_q;
      vld2_d  = vld2_q;
    end
  end

  // S1 registers and the S2 valid/size tags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PART; i++) begin
        part_q[i] <= '0;
      end
      size1_q <= 2'd0;
      vld1_q  <= 1'b0;
      size2_q <= 2'd0;
      vld2_q  <= 1'b0;
    end else begin
      part_q  <= part_d;
      size1_q <= size1_d;
      vld1_q  <= vld1_d;
      size2_q <= size2_d;
      vld2_q  <= vld2_d;
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    spiral_odd_lane #(
      .LANE  (l),
      .OUT_W (OUT_W)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_en   (i_en),
      .i_part (part_q),
      .i_size (size1_q),
      .o_data (lane_s[l])
    );
  end

  assign o_valid   = vld2_q;
  assign o_size    = size2_q;
  assign o_data_0  = lane_s[0];
  assign o_data_1  = lane_s[1];
  assign o_data_2  = lane_s[2];
  assign o_data_3  = lane_s[3];
  assign o_data_4  = lane_s[4];
  assign o_data_5  = lane_s[5];
  assign o_data_6  = lane_s[6];
  assign o_data_7  = lane_s[7];
  assign o_data_8  = lane_s[8];
  assign o_data_9  = lane_s[9];
  assign o_data_10 = lane_s[10];
  assign o_data_11 = lane_s[11];
  assign o_data_12 = lane_s[12];
  assign o_data_13 = lane_s[13];
  assign o_data_14 = lane_s[14];
  assign o_data_15 = lane_s[15];

endmodule
